spm_ctrl: RTL

Sequencer for the serial-parallel multiplier datapath. Accepts an operand pair through a valid/ready handshake. Loads the parallel-in/serial-out multiplier shift register, then drives its shift enable for the full product length. Reassembles the serial product bits returned by the SPM core into a parallel result, which it presents through a second valid/ready handshake. Sits between the bus-facing wrapper and the shift register / SPM core pair.

---
 rtl/spm_pkg.sv | 20 ++
 rtl/spm_ctrl_deser.sv | 63 ++++++
 rtl/spm_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spm_pkg.sv
// spm_pkg: shared types and defaults for the serial-parallel multiplier sequencer.
package spm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DRAIN,
    DONE
  } spm_state_e;

  localparam int unsigned SPM_WIDTH = 64;
  localparam int unsigned SPM_LAT   = 1;

  // Counter width able to hold 2*w without wrapping.
  function automatic int unsigned spm_cnt_w(input int unsigned w);
    return $clog2(2 * w) + 1;
  endfunction

endpackage

// File: rtl/spm_ctrl_deser.sv
// spm_ctrl_deser: delays shift by LAT to mark valid p_bit cycles and shifts
// the returned product bits (LSB first) into a parallel register.
module spm_ctrl_deser
  import spm_pkg::*;
#(
  parameter int unsigned WIDTH = SPM_WIDTH,
  parameter int unsigned LAT   = SPM_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               flush,
  input  logic               shift,
  input  logic               p_bit,
  output logic [2*WIDTH-1:0] prod,
  output logic               cap_done
);

  localparam int unsigned    PW   = 2 * WIDTH;
  localparam int unsigned    CW   = spm_cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(PW - 1);

  logic [LAT-1:0] dl;
  logic [CW-1:0]  cap_cnt;
  logic           mark;

  assign mark = dl[LAT-1];

  // High in the cycle whose edge captures the final product bit, so the FSM
  // leaves DRAIN exactly when prod becomes complete.
  assign cap_done = mark && (cap_cnt == LAST);

  // Delay line tracking which cycles carry a valid p_bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl <= '0;
    end else if (flush) begin
      dl <= '0;
    end else begin
      dl[0] <= shift;
      for (int unsigned i = 1; i < LAT; i++) begin
        dl[i] <= dl[i-1];
      end
    end
  end

  // Capture counter and product shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cnt <= '0;
      prod    <= '0;
    end else if (clr) begin
      cap_cnt <= '0;
      prod    <= '0;
    end else if (flush) begin
      cap_cnt <= '0;
    end else if (mark) begin
      cap_cnt <= cap_cnt + CW'(1);
      prod    <= {p_bit, prod[PW-1:1]};
    end
  end

endmodule

// File: rtl/spm_ctrl.sv
// spm_ctrl: sequencer for the serial-parallel multiplier datapath.
// Optional feature macro SPM_CTRL_ABORT_EN adds an abort input.
module spm_ctrl
  import spm_pkg::*;
#(
  parameter int unsigned WIDTH = SPM_WIDTH,
  parameter int unsigned LAT   = SPM_LAT
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef SPM_CTRL_ABORT_EN
  input  logic               abort,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               ld,
  output logic               shift,
  output logic [WIDTH-1:0]   x_par,
  output logic [WIDTH-1:0]   y_par,
  output logic               spm_clr,
  input  logic               p_bit,
  output logic [2*WIDTH-1:0] prod,
  output logic               prod_valid,
  input  logic               prod_ready,
  output logic               busy
);

  localparam int unsigned   CW   = spm_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

  spm_state_e     state, nxt;
  logic [CW-1:0]  scnt;
  logic           abort_hit;
  logic           cap_done;
  logic           accept;

`ifdef SPM_CTRL_ABORT_EN
  assign abort_hit = abort && ((state == LOAD) || (state == SHIFT) || (state == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign accept = in_valid && (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    nxt        = state;
    in_ready   = 1'b0;
    ld         = 1'b0;
    spm_clr    = 1'b0;
    shift      = 1'b0;
    prod_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = LOAD;
      end
      LOAD: begin
        ld      = 1'b1;
        spm_clr = 1'b1;
        nxt     = SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
        if (scnt == LAST) nxt = DRAIN;
      end
      DRAIN: begin
        if (cap_done) nxt = DONE;
      end
      DONE: begin
        prod_valid = 1'b1;
        if (prod_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
`ifdef SPM_CTRL_ABORT_EN
    if (abort_hit) nxt = IDLE;
`endif
  end

  // Shift counter: counts SHIFT cycles of the current operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        scnt <= '0;
    else if (ld || abort_hit)          scnt <= '0;
    else if (state == SHIFT)           scnt <= scnt + CW'(1);
  end

  // Operand capture on accept; held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_par <= '0;
      y_par <= '0;
    end else if (accept) begin
      x_par <= in_x;
      y_par <= in_y;
    end
  end

  spm_ctrl_deser #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ld),
    .flush    (abort_hit),
    .shift    (shift),
    .p_bit    (p_bit),
    .prod     (prod),
    .cap_done (cap_done)
  );

endmodule
